// File: rtl/segment_reader_if.sv
// segment_reader_if: multiplexed seven-segment bus plus the decoded read-back results.
interface segment_reader_if #(
    parameter int NUM_DIGITS = 2,
    parameter int DW = 1
);
    logic a, b, c, d, e, f, g;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic valid, err;
    logic [3:0] value;
    logic [DW-1:0] digit;
    logic [4*NUM_DIGITS-1:0] scores;
    modport master(output a, b, c, d, e, f, g, digit_sel, input valid, err, value, digit, scores);
    modport slave(input a, b, c, d, e, f, g, digit_sel, output valid, err, value, digit, scores);
endinterface

// File: rtl/segment_reader.sv
// segment_reader: debounces a multiplexed seven-segment bus and decodes each stable frame to a value.
// Define SEGMENT_READER_HEX_EN to also accept the hex glyphs A..F as values 10..15.
module segment_reader #(
    parameter int NUM_DIGITS = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int DW = 1
) (
    input logic clk,
    input logic reset,
    segment_reader_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
    state_t state;
    logic [NUM_DIGITS-1:0] held_sel, sel;
    logic [6:0] held_pat, pat;
    logic [CW-1:0] cnt;
    logic changed, blank, known, legal, fire;
    logic [3:0] dec;
    logic [DW-1:0] idx;
    assign sel = bus.digit_sel;
    assign pat = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
    // Decoding the live sample covers both the settled case and the single-cycle lock.
    always_comb begin
        changed = {sel, pat} != {held_sel, held_pat};
        blank = sel == '0 || pat == '0;
        dec = 4'd0;
        known = 1'b1;
        case (pat)
            7'b1111110: dec = 4'd0;
            7'b0110000: dec = 4'd1;
            7'b1101101: dec = 4'd2;
            7'b1111001: dec = 4'd3;
            7'b0110011: dec = 4'd4;
            7'b1011011: dec = 4'd5;
            7'b1011111: dec = 4'd6;
            7'b1110000: dec = 4'd7;
            7'b1111111: dec = 4'd8;
            7'b1111011: dec = 4'd9;
`ifdef SEGMENT_READER_HEX_EN
            7'b1110111: dec = 4'd10;
            7'b0011111: dec = 4'd11;
            7'b1001110: dec = 4'd12;
            7'b0111101: dec = 4'd13;
            7'b1001111: dec = 4'd14;
            7'b1000111: dec = 4'd15;
`endif
            default: known = 1'b0;
        endcase
        legal = known && $onehot(sel);
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) if (sel[i]) idx = DW'(i);
        fire = changed ? (!blank && STABLE_CYCLES == 1) : (state == SETTLE && cnt == LAST);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            held_sel <= '0;
            held_pat <= '0;
            cnt <= '0;
            bus.valid <= 1'b0;
            bus.err <= 1'b0;
            bus.value <= '0;
            bus.digit <= '0;
            bus.scores <= '0;
        end else begin
            bus.valid <= fire && legal;
            bus.err <= fire && !legal;
            if (fire && legal) begin
                bus.value <= dec;
                bus.digit <= idx;
                bus.scores[idx*4 +: 4] <= dec;
            end
            if (changed) begin
                held_sel <= sel;
                held_pat <= pat;
                cnt <= CW'(1);
                state <= blank ? IDLE : fire ? LOCKED : SETTLE;
            end else if (state == SETTLE) begin
                cnt <= cnt + CW'(1);
                if (fire) state <= LOCKED;
            end
        end
    end
endmodule

// File: tb/tb_segment_reader.sv
// tb_segment_reader: table-driven frames with hand-computed pulses, latency and held outputs.
module tb_segment_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    segment_reader_if #(.NUM_DIGITS(2), .DW(1)) bus();
    segment_reader #(.NUM_DIGITS(2), .STABLE_CYCLES(4), .DW(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] sel;
        logic [6:0] pat;
        int n;
        int nv;
        int ne;
        logic [3:0] val;
        logic [0:0] dig;
        logic [7:0] sc;
    } vec_t;
    vec_t tbl[$];
    logic [6:0] glyph[10];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [1:0] sel, input logic [6:0] pat);
        bus.digit_sel = sel;
        {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = pat;
    endtask
    task automatic run(input int r, input vec_t v);
        int nv = 0, ne = 0, first = 0;
        logic bad = 1'b0, prev = 1'b0;
        drive(v.sel, v.pat);
        for (int k = 1; k <= v.n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid) nv++;
            if (bus.err) ne++;
            if ((bus.valid || bus.err) && first == 0) first = k;
            if ((bus.valid && bus.err) || (prev && (bus.valid || bus.err))) bad = 1'b1;
            prev = bus.valid || bus.err;
        end
        check($sformatf("r%0d.valid_count", r), nv, v.nv);
        check($sformatf("r%0d.err_count", r), ne, v.ne);
        check($sformatf("r%0d.value", r), bus.value, v.val);
        check($sformatf("r%0d.digit", r), bus.digit, v.dig);
        check($sformatf("r%0d.scores", r), bus.scores, v.sc);
        check($sformatf("r%0d.pulse_rules", r), bad, 0);
        if (v.nv + v.ne > 0) check($sformatf("r%0d.latency", r), first, 4);
    endtask
    initial begin
        glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        tbl.push_back('{2'b01, 7'b1111111, 6, 1, 0, 4'd8, 1'b0, 8'h08});
        tbl.push_back('{2'b01, 7'b0110000, 6, 1, 0, 4'd1, 1'b0, 8'h01});
        for (int k = 0; k < 10; k++)
            tbl.push_back('{2'b10, glyph[k], 6, 1, 0, 4'(k), 1'b1, {4'(k), 4'h1}});
        tbl.push_back('{2'b10, 7'b1111111, 2, 0, 0, 4'd9, 1'b1, 8'h91});
        tbl.push_back('{2'b10, 7'b1111110, 6, 1, 0, 4'd0, 1'b1, 8'h01});
        tbl.push_back('{2'b01, 7'b1000001, 6, 0, 1, 4'd0, 1'b1, 8'h01});
        tbl.push_back('{2'b11, 7'b0110000, 6, 0, 1, 4'd0, 1'b1, 8'h01});
        tbl.push_back('{2'b00, 7'b1111001, 20, 0, 0, 4'd0, 1'b1, 8'h01});
        tbl.push_back('{2'b01, 7'b0000000, 20, 0, 0, 4'd0, 1'b1, 8'h01});
        tbl.push_back('{2'b01, 7'b1111001, 6, 1, 0, 4'd3, 1'b0, 8'h03});
        tbl.push_back('{2'b00, 7'b1111001, 6, 0, 0, 4'd3, 1'b0, 8'h03});
        tbl.push_back('{2'b01, 7'b1111001, 6, 1, 0, 4'd3, 1'b0, 8'h03});
        tbl.push_back('{2'b01, 7'b1110000, 6, 1, 0, 4'd7, 1'b0, 8'h07});
`ifdef SEGMENT_READER_HEX_EN
        tbl.push_back('{2'b01, 7'b1110111, 6, 1, 0, 4'd10, 1'b0, 8'h0A});
`else
        tbl.push_back('{2'b01, 7'b1110111, 6, 0, 1, 4'd7, 1'b0, 8'h07});
`endif
        drive(2'b00, 7'b0000000);
        repeat (2) @(negedge clk);
        check("reset.valid", bus.valid, 0);
        check("reset.scores", bus.scores, 0);
        reset = 1'b0;
        run(0, tbl[0]);
        drive(2'b01, 7'b1111110);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset.outputs", {bus.valid, bus.err, bus.value, bus.digit, bus.scores}, 0);
        reset = 1'b0;
        for (int r = 1; r < tbl.size(); r++) run(r, tbl[r]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
